// File: rtl/skipring_mc.sv
// skipring_mc
//   Multi-channel skip ring. A single LEN-bit pattern register rotates one
//   place on every qualifying advance (E & TICK, not blocked by LOAD or a
//   finished one-shot). Each of NCH channels ANDs the pre-rotation pattern
//   with its own LEN-bit mask and emits a one-cycle pulse plus a held level
//   when any masked bit is set.
//
// Ports
//   iCLK     system clock, rising edge
//   RST      asynchronous active-high reset
//   E        enable for TICK
//   TICK     one-cycle advance strobe
//   LOAD     load rSEL into the ring, clear position and done
//   DIR      0 = rotate left, 1 = rotate right
//   ONESHOT  1 = stop after LEN advances
//   rSEL     pattern loaded by LOAD
//   MASK     per-channel masks, channel c at MASK[c*LEN +: LEN]
//   oPULSE   per-channel one-cycle hit pulse
//   oLVL     per-channel hit level, held between advances
//   oB0      ring bit 0
//   oPOS     advances since LOAD/reset, modulo LEN
//   oWRAP    one-cycle pulse on position wrap LEN-1 -> 0
//   oDONE    one-shot finished, held until LOAD/RST
module skipring_mc #(
  parameter int unsigned       LEN    = 16,
  parameter int unsigned       NCH    = 4,
  parameter logic [LEN-1:0]    defSEL = LEN'(1),
  parameter int unsigned       PW     = $clog2(LEN)
) (
  input  logic               iCLK,
  input  logic               RST,
  input  logic               E,
  input  logic               TICK,
  input  logic               LOAD,
  input  logic               DIR,
  input  logic               ONESHOT,
  input  logic [LEN-1:0]     rSEL,
  input  logic [NCH*LEN-1:0] MASK,
  output logic [NCH-1:0]     oPULSE,
  output logic [NCH-1:0]     oLVL,
  output logic               oB0,
  output logic [PW-1:0]      oPOS,
  output logic               oWRAP,
  output logic               oDONE
);

  typedef enum logic {ST_RUN, ST_STOP} state_t;

  state_t           r_state;
  logic [LEN-1:0]   r_sel;
  logic [PW-1:0]    r_pos;
  logic [NCH-1:0]   r_pulse;
  logic [NCH-1:0]   r_lvl;
  logic             r_wrap;

  logic             w_done;
  logic             w_adv;
  logic             w_last;
  logic [NCH-1:0]   w_hit;
  logic [LEN-1:0]   w_rot;

  assign w_done = (r_state == ST_STOP);
  assign w_adv  = E & TICK & ~LOAD & ~(ONESHOT & w_done);
  assign w_last = (r_pos == PW'(LEN - 1));

  // Hits are taken from the ring before this advance rotates it.
  always_comb begin
    w_hit = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_hit[c] = |(r_sel & MASK[c*LEN +: LEN]);
    end
  end

  always_comb begin
    if (DIR) w_rot = {r_sel[0], r_sel[LEN-1:1]};
    else     w_rot = {r_sel[LEN-2:0], r_sel[LEN-1]};
  end

  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_RUN;
      r_sel   <= defSEL;
      r_pos   <= '0;
      r_pulse <= '0;
      r_lvl   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_pulse <= '0;
      r_wrap  <= 1'b0;
      if (LOAD) begin
        // A TICK coinciding with LOAD is dropped; oLVL keeps its last value.
        r_sel   <= rSEL;
        r_pos   <= '0;
        r_state <= ST_RUN;
      end else if (w_adv) begin
        r_pulse <= w_hit;
        r_lvl   <= w_hit;
        r_sel   <= w_rot;
        if (w_last) begin
          r_pos  <= '0;
          r_wrap <= 1'b1;
          if (ONESHOT) r_state <= ST_STOP;
        end else begin
          r_pos <= r_pos + 1'b1;
        end
      end
    end
  end

  assign oPULSE = r_pulse;
  assign oLVL   = r_lvl;
  assign oB0    = r_sel[0];
  assign oPOS   = r_pos;
  assign oWRAP  = r_wrap;
  assign oDONE  = w_done;

endmodule

// File: tb/tb_skipring_mc.sv
module tb_skipring_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: LEN=16, NCH=4
  logic        a_e, a_tick, a_load, a_dir, a_one;
  logic [15:0] a_rsel;
  logic [63:0] a_mask;
  logic [3:0]  a_pulse, a_lvl;
  logic        a_b0, a_wrap, a_done;
  logic [3:0]  a_pos;

  // Instance B: LEN=5, NCH=1
  logic        b_e, b_tick, b_load, b_dir, b_one;
  logic [4:0]  b_rsel;
  logic [4:0]  b_mask;
  logic [0:0]  b_pulse, b_lvl;
  logic        b_b0, b_wrap, b_done;
  logic [2:0]  b_pos;

  skipring_mc #(.LEN(16), .NCH(4), .defSEL(16'h0001)) dut_a (
    .iCLK(clk), .RST(rst), .E(a_e), .TICK(a_tick), .LOAD(a_load), .DIR(a_dir),
    .ONESHOT(a_one), .rSEL(a_rsel), .MASK(a_mask), .oPULSE(a_pulse), .oLVL(a_lvl),
    .oB0(a_b0), .oPOS(a_pos), .oWRAP(a_wrap), .oDONE(a_done)
  );

  skipring_mc #(.LEN(5), .NCH(1), .defSEL(5'b00001)) dut_b (
    .iCLK(clk), .RST(rst), .E(b_e), .TICK(b_tick), .LOAD(b_load), .DIR(b_dir),
    .ONESHOT(b_one), .rSEL(b_rsel), .MASK(b_mask), .oPULSE(b_pulse), .oLVL(b_lvl),
    .oB0(b_b0), .oPOS(b_pos), .oWRAP(b_wrap), .oDONE(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the ring is the loaded pattern plus a net rotation
  // count k; ring bit i equals pattern bit (i - k) mod len.
  typedef struct {
    logic [15:0] pat;
    int          k;
    int          pos;
    bit          done;
    logic [3:0]  pulse;
    logic [3:0]  lvl;
    bit          wrap;
  } mst_t;

  mst_t ma, mb;

  function automatic bit selbit(mst_t s, int len, int i);
    int j;
    j = ((i - s.k) % len + len) % len;
    return s.pat[j];
  endfunction

  function automatic mst_t mreset(logic [15:0] def);
    mst_t s;
    s.pat = def; s.k = 0; s.pos = 0; s.done = 0;
    s.pulse = '0; s.lvl = '0; s.wrap = 0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, int len, int nch, bit e, bit tick, bit load,
                                 bit dir, bit one, logic [15:0] rsel, logic [63:0] mask);
    mst_t n;
    bit   hit;
    n = s;
    n.pulse = '0;
    n.wrap  = 0;
    if (load) begin
      n.pat = rsel; n.k = 0; n.pos = 0; n.done = 0;
    end else if (e && tick && !(one && s.done)) begin
      for (int c = 0; c < nch; c++) begin
        hit = 0;
        for (int i = 0; i < len; i++)
          if (selbit(s, len, i) && mask[c*len + i]) hit = 1;
        n.pulse[c] = hit;
        n.lvl[c]   = hit;
      end
      n.k = dir ? s.k - 1 : s.k + 1;
      n.k = (n.k % len + len) % len;
      if (s.pos == len - 1) begin
        n.pos = 0; n.wrap = 1;
        if (one) n.done = 1;
      end else begin
        n.pos = s.pos + 1;
      end
    end
    return n;
  endfunction

  task automatic compare_all();
    check("a_pulse", 32'(a_pulse), 32'(ma.pulse));
    check("a_lvl",   32'(a_lvl),   32'(ma.lvl));
    check("a_b0",    32'(a_b0),    32'(selbit(ma, 16, 0)));
    check("a_pos",   32'(a_pos),   32'(ma.pos));
    check("a_wrap",  32'(a_wrap),  32'(ma.wrap));
    check("a_done",  32'(a_done),  32'(ma.done));
    check("b_pulse", 32'(b_pulse), 32'(mb.pulse[0]));
    check("b_lvl",   32'(b_lvl),   32'(mb.lvl[0]));
    check("b_b0",    32'(b_b0),    32'(selbit(mb, 5, 0)));
    check("b_pos",   32'(b_pos),   32'(mb.pos));
    check("b_wrap",  32'(b_wrap),  32'(mb.wrap));
    check("b_done",  32'(b_done),  32'(mb.done));
  endtask

  // Inputs are set at +1 after a rising edge; one clock edge is consumed.
  task automatic step();
    ma = mstep(ma, 16, 4, a_e, a_tick, a_load, a_dir, a_one, a_rsel, a_mask);
    mb = mstep(mb, 5, 1, b_e, b_tick, b_load, b_dir, b_one, {11'b0, b_rsel}, {59'b0, b_mask});
    @(posedge clk); #1;
    compare_all();
  endtask

  // Asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    ma = mreset(16'h0001);
    mb = mreset(16'h0001);
    check("rst_a_pulse", 32'(a_pulse), 32'h0);
    check("rst_a_lvl",   32'(a_lvl),   32'h0);
    check("rst_a_b0",    32'(a_b0),    32'h1);
    check("rst_a_pos",   32'(a_pos),   32'h0);
    check("rst_a_wrap",  32'(a_wrap),  32'h0);
    check("rst_a_done",  32'(a_done),  32'h0);
    check("rst_b_b0",    32'(b_b0),    32'h1);
    check("rst_b_pos",   32'(b_pos),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    compare_all();
  endtask

  task automatic a_idle();
    a_e = 1'b1; a_tick = 1'b0; a_load = 1'b0; a_dir = 1'b0; a_one = 1'b0; a_rsel = '0;
  endtask

  typedef struct {
    bit          e, tick, load, dir;
    logic [15:0] rsel;
    bit          b0, pulse0, lvl0, wrap;
    int          pos;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt1, cnt2, cnt3;

    // e, tick, load, dir, rsel, b0, pulse0, lvl0, wrap, pos  (MASK_0 = CCCC)
    tbl[0]  = '{1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 2};
    tbl[2]  = '{1, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 3};
    tbl[3]  = '{1, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 4};
    tbl[4]  = '{0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 4};
    tbl[5]  = '{1, 1, 1, 0, 16'h0003, 1, 0, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 1, 16'h0000, 1, 0, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 1, 16'h0000, 0, 1, 1, 0, 2};
    tbl[8]  = '{1, 1, 0, 0, 16'h0000, 1, 1, 1, 0, 3};
    tbl[9]  = '{1, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 3};
    tbl[10] = '{1, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 0};
    tbl[11] = '{1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1};

    rst = 1'b0;
    a_idle(); a_mask = '0;
    b_e = 1'b0; b_tick = 1'b0; b_load = 1'b0; b_dir = 1'b0; b_one = 1'b0;
    b_rsel = '0; b_mask = '0;
    @(posedge clk); #1;
    do_reset();

    // Table-driven vectors
    a_mask = 64'h0000_0000_0000_CCCC;
    for (int r = 0; r < 12; r++) begin
      a_e = tbl[r].e; a_tick = tbl[r].tick; a_load = tbl[r].load;
      a_dir = tbl[r].dir; a_rsel = tbl[r].rsel;
      step();
      check("tbl_b0",    32'(a_b0),     32'(tbl[r].b0));
      check("tbl_pulse", 32'(a_pulse[0]), 32'(tbl[r].pulse0));
      check("tbl_lvl",   32'(a_lvl[0]),   32'(tbl[r].lvl0));
      check("tbl_wrap",  32'(a_wrap),   32'(tbl[r].wrap));
      check("tbl_pos",   32'(a_pos),    32'(tbl[r].pos));
    end

    // Continuous left rotation from reset, 32 ticks
    a_idle();
    do_reset();
    a_mask = 64'h0000_0000_0000_CCCC;
    a_tick = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      step();
      check("cont_pulse", 32'(a_pulse[0]), 32'(((t - 1) % 4) >= 2));
      check("cont_wrap",  32'(a_wrap), 32'(t == 16 || t == 32));
    end
    a_tick = 1'b0;
    check("cont_pos_end", 32'(a_pos), 32'h0);

    // Multi-channel masks, 16 ticks
    do_reset();
    a_mask = {16'h8001, 16'h0000, 16'hFFFF, 16'hCCCC};
    cnt1 = 0; cnt2 = 0; cnt3 = 0;
    a_tick = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      step();
      cnt1 += int'(a_pulse[1]);
      cnt2 += int'(a_pulse[2]);
      cnt3 += int'(a_pulse[3]);
      check("mc_ch3", 32'(a_pulse[3]), 32'(t == 1 || t == 16));
    end
    a_tick = 1'b0;
    check("mc_cnt1", 32'(cnt1), 32'd16);
    check("mc_cnt2", 32'(cnt2), 32'd0);
    check("mc_cnt3", 32'(cnt3), 32'd2);
    check("mc_lvl3", 32'(a_lvl[3]), 32'h1);

    // One-shot, right rotation
    a_load = 1'b1; a_rsel = 16'h8000; a_one = 1'b1; a_dir = 1'b1;
    step();
    a_load = 1'b0; a_tick = 1'b1;
    cnt1 = 0;
    for (int t = 1; t <= 20; t++) begin
      step();
      cnt1 += int'(a_pulse[1]);
      check("os_done", 32'(a_done), 32'(t >= 16));
      if (t > 16) check("os_nopulse", 32'(a_pulse), 32'h0);
    end
    check("os_adv_cnt", 32'(cnt1), 32'd16);
    check("os_pos", 32'(a_pos), 32'h0);
    // Dropping ONESHOT in STOP resumes advancing; DONE is kept
    a_one = 1'b0;
    step();
    check("os_resume_pulse", 32'(a_pulse[1]), 32'h1);
    check("os_resume_done",  32'(a_done), 32'h1);
    a_tick = 1'b0; a_load = 1'b1; a_rsel = 16'h0001;
    step();
    check("os_load_clr", 32'(a_done), 32'h0);
    a_load = 1'b0; a_dir = 1'b0;

    // LOAD/TICK collision at position 5, then E=0
    a_tick = 1'b1;
    repeat (5) step();
    check("col_pre_pos", 32'(a_pos), 32'd5);
    a_load = 1'b1; a_rsel = 16'h00F0;
    step();
    check("col_pos",   32'(a_pos), 32'h0);
    check("col_pulse", 32'(a_pulse), 32'h0);
    check("col_b0",    32'(a_b0), 32'h0);
    a_load = 1'b0; a_e = 1'b0;
    step();
    check("e0_pos", 32'(a_pos), 32'h0);
    check("e0_pulse", 32'(a_pulse), 32'h0);
    a_e = 1'b1;

    // Mid-run asynchronous reset at position 9
    a_load = 1'b1; a_rsel = 16'h0F0F; a_tick = 1'b0;
    step();
    a_load = 1'b0; a_tick = 1'b1;
    repeat (9) step();
    check("mr_pos9", 32'(a_pos), 32'd9);
    a_tick = 1'b0;
    do_reset();
    a_tick = 1'b1;
    step();
    check("mr_first_hit", 32'(a_pulse), 32'b1010);
    a_tick = 1'b0;

    // LEN=5 instance
    b_e = 1'b1; b_load = 1'b1; b_rsel = 5'b00011; b_mask = 5'b00001;
    step();
    b_load = 1'b0; b_tick = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      check("l5_pulse", 32'(b_pulse), 32'((t % 5) == 1 || (t % 5) == 0));
      check("l5_wrap",  32'(b_wrap),  32'(t == 5 || t == 10));
      check("l5_posmax", 32'(b_pos <= 3'd4), 32'h1);
    end

    // Randomised traffic against the model
    for (int n = 0; n < 500; n++) begin
      a_e    = ($urandom_range(0, 7) != 0);
      a_tick = $urandom_range(0, 1);
      a_load = ($urandom_range(0, 19) == 0);
      a_dir  = $urandom_range(0, 1);
      a_one  = ($urandom_range(0, 3) == 0) ? ~a_one : a_one;
      a_rsel = 16'($urandom);
      if ($urandom_range(0, 15) == 0) a_mask = {$urandom, $urandom};
      b_e    = ($urandom_range(0, 7) != 0);
      b_tick = $urandom_range(0, 1);
      b_load = ($urandom_range(0, 19) == 0);
      b_dir  = $urandom_range(0, 1);
      b_one  = ($urandom_range(0, 3) == 0) ? ~b_one : b_one;
      b_rsel = 5'($urandom);
      if ($urandom_range(0, 15) == 0) b_mask = 5'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
